// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback logic for the pipelined RV32I core.
// Extends load data, selects the register-file write data and counts retirements.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallW,
  input  logic                     FlushW,
  input  logic                     ValidM,
  input  logic                     RegWriteM,
  input  logic [1:0]               ResultSrcM,
  input  logic [2:0]               Funct3M,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]    ALUResultM,
  input  logic [DATA_WIDTH-1:0]    ReadDataM,
  input  logic [DATA_WIDTH-1:0]    PCPlus4M,
  output logic [ADDRESS_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]    ResultW,
  output logic                     RegWriteW,
  output logic [31:0]              InstRetW
);

  localparam logic [1:0] SrcAlu  = 2'b00;
  localparam logic [1:0] SrcLoad = 2'b01;
  localparam logic [1:0] SrcPc4  = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  logic                     valid_q;
  logic                     regwrite_q;
  logic [1:0]               src_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [1:0]               off_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    pc4_q;
  logic [31:0]              instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      instret_q  <= '0;
    end else if (FlushW) begin
      // Bubble: counter is left alone, even if a stall is also requested.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
    end else if (!StallW) begin
      valid_q    <= ValidM;
      regwrite_q <= RegWriteM & ValidM;
      src_q      <= ResultSrcM;
      funct3_q   <= Funct3M;
      rd_q       <= RdM;
      off_q      <= ALUResultM[1:0];
      alu_q      <= ALUResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      if (ValidM) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;

  always_comb begin
    ld_byte = rdata_q[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    case (funct3_q)
      F3Lb:    load_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3Lbu:   load_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3Lh:    load_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3Lhu:   load_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    ResultW = alu_q;
    case (src_q)
      SrcAlu:  ResultW = alu_q;
      SrcLoad: ResultW = load_ext;
      SrcPc4:  ResultW = pc4_q;
      default: ResultW = alu_q;
    endcase
  end

  // x0 is hardwired to zero, so never raise the write enable for it.
  assign RegWriteW = regwrite_q & (rd_q != '0);
  assign RdW       = rd_q;
  assign InstRetW  = instret_q;

  logic unused_valid;
  assign unused_valid = valid_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver queues expected outputs per cycle,
// a monitor compares them one edge later.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        StallW;
  logic        FlushW;
  logic        ValidM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [31:0] InstRetW;

  writeback_stage #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .ReadDataM  (ReadDataM),
    .PCPlus4M   (PCPlus4M),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .RegWriteW  (RegWriteW),
    .InstRetW   (InstRetW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drive_done = 1'b0;

  // Monitor: the W outputs update on every posedge, so one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (RdW !== e.rd) begin
          errors++;
          $display("FAIL %s RdW got %0d expected %0d", e.name, RdW, e.rd);
        end
        if (ResultW !== e.res) begin
          errors++;
          $display("FAIL %s ResultW got %08h expected %08h", e.name, ResultW, e.res);
        end
        if (RegWriteW !== e.we) begin
          errors++;
          $display("FAIL %s RegWriteW got %0b expected %0b", e.name, RegWriteW, e.we);
        end
        if (InstRetW !== e.cnt) begin
          errors++;
          $display("FAIL %s InstRetW got %08h expected %08h", e.name, InstRetW, e.cnt);
        end
      end
    end
  end

  // Inputs are already applied at a negedge; queue the result due at the next posedge.
  task automatic cyc(input string name, input logic [4:0] rd, input logic [31:0] res,
                     input logic we, input logic [31:0] cnt);
    exp_t e;
    e.name = name;
    e.rd   = rd;
    e.res  = res;
    e.we   = we;
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4);
    ValidM     = v;
    RegWriteM  = rw;
    ResultSrcM = src;
    Funct3M    = f3;
    RdM        = rd;
    ALUResultM = alu;
    ReadDataM  = rdata;
    PCPlus4M   = pc4;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 5'($urandom),
           $urandom, $urandom, $urandom);
  endtask

  localparam logic [31:0] Word = 32'h80F1_7F83;

  initial begin
    rst = 1'b1;
    StallW = 1'b0;
    FlushW = 1'b0;
    rand_in();
    StallW = 1'($urandom);
    FlushW = 1'($urandom);
    cyc("reset0", 5'd0, 32'h0, 1'b0, 32'd0);
    rand_in();
    StallW = 1'($urandom);
    FlushW = 1'($urandom);
    cyc("reset1", 5'd0, 32'h0, 1'b0, 32'd0);

    rst = 1'b0;
    StallW = 1'b0;
    FlushW = 1'b0;
    // Load extension on byte lanes 83 7F F1 80.
    set_in(1, 1, 2'b01, 3'b000, 5'd3, 32'h1000, Word, 32'h0);
    cyc("lb_off0", 5'd3, 32'hFFFF_FF83, 1'b1, 32'd1);
    set_in(1, 1, 2'b01, 3'b100, 5'd3, 32'h1001, Word, 32'h0);
    cyc("lbu_off1", 5'd3, 32'h0000_007F, 1'b1, 32'd2);
    set_in(1, 1, 2'b01, 3'b001, 5'd3, 32'h1002, Word, 32'h0);
    cyc("lh_off2", 5'd3, 32'hFFFF_80F1, 1'b1, 32'd3);
    set_in(1, 1, 2'b01, 3'b101, 5'd3, 32'h1003, Word, 32'h0);
    cyc("lhu_off3", 5'd3, 32'h0000_80F1, 1'b1, 32'd4);
    set_in(1, 1, 2'b01, 3'b010, 5'd3, 32'h1000, Word, 32'h0);
    cyc("lw", 5'd3, 32'h80F1_7F83, 1'b1, 32'd5);
    set_in(1, 1, 2'b01, 3'b001, 5'd3, 32'h1000, Word, 32'h0);
    cyc("lh_off0", 5'd3, 32'h0000_7F83, 1'b1, 32'd6);
    set_in(1, 1, 2'b01, 3'b000, 5'd3, 32'h1003, Word, 32'h0);
    cyc("lb_off3", 5'd3, 32'hFFFF_FF80, 1'b1, 32'd7);
    set_in(1, 1, 2'b01, 3'b100, 5'd3, 32'h1002, Word, 32'h0);
    cyc("lbu_off2", 5'd3, 32'h0000_00F1, 1'b1, 32'd8);
    set_in(1, 1, 2'b01, 3'b011, 5'd3, 32'h1001, Word, 32'h0);
    cyc("f3_011", 5'd3, 32'h80F1_7F83, 1'b1, 32'd9);
    set_in(1, 1, 2'b00, 3'b000, 5'd3, 32'h1234_5678, Word, 32'h0);
    cyc("src_alu", 5'd3, 32'h1234_5678, 1'b1, 32'd10);
    set_in(1, 1, 2'b11, 3'b000, 5'd3, 32'hDEAD_BEEF, Word, 32'h0);
    cyc("src_rsvd", 5'd3, 32'hDEAD_BEEF, 1'b1, 32'd11);

    // PC+4 select and x0 suppression.
    set_in(1, 1, 2'b10, 3'b000, 5'd5, 32'h0, 32'h0, 32'h104);
    cyc("pc4_rd5", 5'd5, 32'h104, 1'b1, 32'd12);
    set_in(1, 1, 2'b10, 3'b000, 5'd0, 32'h0, 32'h0, 32'h104);
    cyc("pc4_rd0", 5'd0, 32'h104, 1'b0, 32'd13);
    set_in(0, 1, 2'b10, 3'b000, 5'd5, 32'h0, 32'h0, 32'h200);
    cyc("invalid", 5'd5, 32'h200, 1'b0, 32'd13);

    // Stall holds everything, then flush wins over stall.
    set_in(1, 1, 2'b00, 3'b000, 5'd7, 32'hAAAA_0007, 32'h0, 32'h0);
    cyc("cap_rd7", 5'd7, 32'hAAAA_0007, 1'b1, 32'd14);
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 2'b10, 3'b000, 5'd9, 32'h55, 32'h66, 32'h77 + 32'(i));
      cyc("stall", 5'd7, 32'hAAAA_0007, 1'b1, 32'd14);
    end
    FlushW = 1'b1;
    cyc("flush_stall", 5'd0, 32'h0, 1'b0, 32'd14);
    FlushW = 1'b0;

    // Counter wrap: preload just below the top while stalled.
    set_in(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    cyc("preload", 5'd0, 32'h0, 1'b0, 32'hFFFF_FFFE);
    StallW = 1'b0;
    set_in(1, 1, 2'b00, 3'b000, 5'd1, 32'h1, 32'h0, 32'h0);
    cyc("cnt_top", 5'd1, 32'h1, 1'b1, 32'hFFFF_FFFF);
    set_in(0, 1, 2'b00, 3'b000, 5'd1, 32'h2, 32'h0, 32'h0);
    cyc("cnt_bubble", 5'd1, 32'h2, 1'b0, 32'hFFFF_FFFF);
    set_in(1, 1, 2'b00, 3'b000, 5'd1, 32'h3, 32'h0, 32'h0);
    cyc("cnt_wrap", 5'd1, 32'h3, 1'b1, 32'h0);

    // Reset beats flush and stall mid-stream.
    set_in(1, 1, 2'b00, 3'b000, 5'd4, 32'h9, 32'h0, 32'h0);
    cyc("pre_rst", 5'd4, 32'h9, 1'b1, 32'd1);
    rst = 1'b1;
    StallW = 1'b1;
    FlushW = 1'b1;
    cyc("rst_mid", 5'd0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    StallW = 1'b0;
    FlushW = 1'b0;
    drive_done = 1'b1;
  end

  initial begin
    int waited;
    wait (drive_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
